mutation_sweep: RTL and testbench

Sequencer that runs a mutation-coverage sweep over the reference/mutant miter in simulation or on an emulation target. For each mutation index from 1 to NUM_MUTS, it drives the shared mutation select and the shared active-low core reset. It then runs the miter for a bounded number of cycles and classifies the mutant as killed (its outputs diverged) or survived. Each result is reported over a valid/ready handshake, and a running kill count is kept. Index 0 is the unmutated reference core and is never selected.

---
 rtl/mutation_sweep.sv | 134 +++++++++++++
 tb/tb_mutation_sweep.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mutation_sweep.sv
// Mutation-coverage sweep sequencer: steps the mutant select through 1..NUM_MUTS,
// resets and runs the reference/mutant miter, and reports killed/survived per mutant.
module mutation_sweep #(
   parameter int MUT_W      = 8,
   parameter int NUM_MUTS   = 16,
   parameter int RST_CYCLES = 4,
   parameter int RUN_CYCLES = 1000,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [MUT_W-1:0] mutsel,
   output logic             core_resetn,
   input  logic             mismatch,
   input  logic             ref_trap,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [MUT_W-1:0] result_idx,
   output logic             result_killed,
   output logic [CNT_W-1:0] result_cycle,
   output logic [MUT_W:0]   killed_count
);

   localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   localparam logic [MUT_W-1:0] LAST_MUT = MUT_W'(NUM_MUTS);
   localparam logic [MUT_W-1:0] MUT_ONE  = MUT_W'(1);
   localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
   localparam logic [RST_W-1:0] RST_ONE  = RST_W'(1);
   localparam logic [MUT_W:0]   KC_ONE   = {{MUT_W{1'b0}}, 1'b1};
   localparam logic [MUT_W:0]   KC_MAX   = {(MUT_W+1){1'b1}};

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RESET  = 3'd1,
      S_RUN    = 3'd2,
      S_REPORT = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t           state;
   logic [RST_W-1:0] rst_cnt;
   logic [CNT_W-1:0] run_cnt;

   // Sweep sequencer; every output is a register updated on the state transitions.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= S_IDLE;
         rst_cnt       <= '0;
         run_cnt       <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         mutsel        <= '0;
         core_resetn   <= 1'b0;
         result_valid  <= 1'b0;
         result_idx    <= '0;
         result_killed <= 1'b0;
         result_cycle  <= '0;
         killed_count  <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state        <= S_RESET;
                  mutsel       <= MUT_ONE;
                  killed_count <= '0;
                  done         <= 1'b0;
                  busy         <= 1'b1;
                  rst_cnt      <= '0;
               end
            end
            S_RESET: begin
               if (rst_cnt == RST_LAST) begin
                  state       <= S_RUN;
                  core_resetn <= 1'b1;
                  run_cnt     <= '0;
               end else begin
                  rst_cnt <= rst_cnt + RST_ONE;
               end
            end
            S_RUN: begin
               run_cnt <= run_cnt + CNT_ONE;
               // A divergence outranks a trap or timeout seen in the same cycle.
               if (mismatch) begin
                  state         <= S_REPORT;
                  core_resetn   <= 1'b0;
                  result_valid  <= 1'b1;
                  result_idx    <= mutsel;
                  result_killed <= 1'b1;
                  result_cycle  <= run_cnt;
                  if (killed_count != KC_MAX) begin
                     killed_count <= killed_count + KC_ONE;
                  end
               end else if (ref_trap || (run_cnt == RUN_LAST)) begin
                  state         <= S_REPORT;
                  core_resetn   <= 1'b0;
                  result_valid  <= 1'b1;
                  result_idx    <= mutsel;
                  result_killed <= 1'b0;
                  result_cycle  <= '0;
               end
            end
            S_REPORT: begin
               if (result_ready) begin
                  result_valid <= 1'b0;
                  if (mutsel == LAST_MUT) begin
                     state  <= S_DONE;
                     mutsel <= '0;
                     busy   <= 1'b0;
                     done   <= 1'b1;
                  end else begin
                     state   <= S_RESET;
                     mutsel  <= mutsel + MUT_ONE;
                     rst_cnt <= '0;
                  end
               end
            end
            default: begin
               state        <= S_IDLE;
               busy         <= 1'b0;
               done         <= 1'b0;
               core_resetn  <= 1'b0;
               result_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mutation_sweep.sv
// Directed bench for mutation_sweep with NUM_MUTS=3, RST_CYCLES=4, RUN_CYCLES=10.
module tb_mutation_sweep;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        busy, done, core_resetn;
   logic [7:0]  mutsel, result_idx;
   logic        mismatch = 1'b0;
   logic        ref_trap = 1'b0;
   logic        result_valid, result_killed;
   logic        result_ready = 1'b1;
   logic [15:0] result_cycle;
   logic [8:0]  killed_count;

   int tests = 0;
   int fails = 0;

   mutation_sweep #(
      .MUT_W(8), .NUM_MUTS(3), .RST_CYCLES(4), .RUN_CYCLES(10), .CNT_W(16)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .mutsel(mutsel), .core_resetn(core_resetn), .mismatch(mismatch),
      .ref_trap(ref_trap), .result_valid(result_valid), .result_ready(result_ready),
      .result_idx(result_idx), .result_killed(result_killed),
      .result_cycle(result_cycle), .killed_count(killed_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      mismatch = 1'b0;
      ref_trap = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   // Pulses start for one edge; returns just after that edge (edge 0 of the sweep).
   task automatic start_sweep();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      tests++;
      if ({busy, done, core_resetn, result_valid, result_killed} !== 5'b00000) begin
         fails++;
         $display("FAIL reset_flags got %b expected 00000",
                  {busy, done, core_resetn, result_valid, result_killed});
      end
      tests++;
      if ({mutsel, result_idx, result_cycle, killed_count} !== 41'd0) begin
         fails++;
         $display("FAIL reset_values mutsel=%0d idx=%0d cycle=%0d kc=%0d expected all 0",
                  mutsel, result_idx, result_cycle, killed_count);
      end
   endtask

   // All-survivor sweep; also pulses start mid-sweep, which must be ignored.
   task automatic test_full_sweep();
      int nres = 0;
      int done_at = 0;
      int first_res_at = 0;
      logic [7:0]  idx_log [3];
      logic        kill_log [3];
      logic [15:0] cyc_log [3];
      do_reset();
      result_ready = 1'b1;
      start_sweep();
      tests++;
      if ({busy, core_resetn, mutsel} !== {1'b1, 1'b0, 8'd1}) begin
         fails++;
         $display("FAIL sweep_start busy=%b core_resetn=%b mutsel=%0d expected 1 0 1",
                  busy, core_resetn, mutsel);
      end
      for (int i = 1; i <= 60; i++) begin
         start = (i == 5) ? 1'b1 : 1'b0;
         tick();
         start = 1'b0;
         if (i == 3) begin
            tests++;
            if (core_resetn !== 1'b0) begin
               fails++;
               $display("FAIL rst_hold core_resetn=%b expected 0", core_resetn);
            end
         end
         if (i == 4) begin
            tests++;
            if (core_resetn !== 1'b1) begin
               fails++;
               $display("FAIL rst_release core_resetn=%b expected 1", core_resetn);
            end
         end
         if (result_valid === 1'b1 && nres < 3) begin
            if (nres == 0) first_res_at = i;
            idx_log[nres]  = result_idx;
            kill_log[nres] = result_killed;
            cyc_log[nres]  = result_cycle;
            nres++;
         end
         if (done === 1'b1) begin
            done_at = i;
            break;
         end
      end
      tests++;
      if (first_res_at != 14) begin
         fails++;
         $display("FAIL first_result_time got %0d expected 14", first_res_at);
      end
      tests++;
      if (done_at != 45) begin
         fails++;
         $display("FAIL done_time got %0d expected 45", done_at);
      end
      tests++;
      if (nres != 3) begin
         fails++;
         $display("FAIL result_count got %0d expected 3", nres);
      end
      for (int j = 0; j < nres; j++) begin
         tests++;
         if ({idx_log[j], kill_log[j], cyc_log[j]} !== {8'(j + 1), 1'b0, 16'd0}) begin
            fails++;
            $display("FAIL survivor_result%0d idx=%0d killed=%b cycle=%0d expected %0d 0 0",
                     j, idx_log[j], kill_log[j], cyc_log[j], j + 1);
         end
      end
      tests++;
      if ({busy, done, mutsel, killed_count} !== {1'b0, 1'b1, 8'd0, 9'd0}) begin
         fails++;
         $display("FAIL sweep_end busy=%b done=%b mutsel=%0d kc=%0d expected 0 1 0 0",
                  busy, done, mutsel, killed_count);
      end
   endtask

   // Mutant 2 killed at run cycle 5; then a start in DONE begins a fresh sweep.
   task automatic test_kill_and_restart();
      int done_at = 0;
      int kills = 0;
      do_reset();
      result_ready = 1'b1;
      start_sweep();
      for (int i = 1; i <= 60; i++) begin
         tick();
         mismatch = (i == 24) ? 1'b1 : 1'b0;
         if (result_valid === 1'b1 && result_killed === 1'b1) kills++;
         if (i == 25) begin
            tests++;
            if ({result_valid, result_idx, result_killed, result_cycle, core_resetn} !==
                {1'b1, 8'd2, 1'b1, 16'd5, 1'b0}) begin
               fails++;
               $display("FAIL kill_result valid=%b idx=%0d killed=%b cycle=%0d rn=%b expected 1 2 1 5 0",
                        result_valid, result_idx, result_killed, result_cycle, core_resetn);
            end
         end
         if (i == 26) begin
            tests++;
            if ({result_valid, busy, core_resetn, mutsel} !== {1'b0, 1'b1, 1'b0, 8'd3}) begin
               fails++;
               $display("FAIL next_reset valid=%b busy=%b rn=%b mutsel=%0d expected 0 1 0 3",
                        result_valid, busy, core_resetn, mutsel);
            end
         end
         if (done === 1'b1) begin
            done_at = i;
            break;
         end
      end
      tests++;
      if (done_at != 41 || kills != 1) begin
         fails++;
         $display("FAIL kill_sweep done_at=%0d kills=%0d expected 41 1", done_at, kills);
      end
      tests++;
      if (killed_count !== 9'd1) begin
         fails++;
         $display("FAIL kill_count got %0d expected 1", killed_count);
      end
      start_sweep();
      tests++;
      if ({done, busy, mutsel, killed_count} !== {1'b0, 1'b1, 8'd1, 9'd0}) begin
         fails++;
         $display("FAIL restart done=%b busy=%b mutsel=%0d kc=%0d expected 0 1 1 0",
                  done, busy, mutsel, killed_count);
      end
   endtask

   task automatic test_trap_priority();
      do_reset();
      result_ready = 1'b1;
      start_sweep();
      for (int i = 1; i <= 7; i++) tick();
      mismatch = 1'b1;
      ref_trap = 1'b1;
      tick();
      mismatch = 1'b0;
      ref_trap = 1'b0;
      tests++;
      if ({result_valid, result_idx, result_killed, result_cycle, killed_count} !==
          {1'b1, 8'd1, 1'b1, 16'd3, 9'd1}) begin
         fails++;
         $display("FAIL both_flags valid=%b idx=%0d killed=%b cycle=%0d kc=%0d expected 1 1 1 3 1",
                  result_valid, result_idx, result_killed, result_cycle, killed_count);
      end
      do_reset();
      start_sweep();
      for (int i = 1; i <= 7; i++) tick();
      ref_trap = 1'b1;
      tick();
      ref_trap = 1'b0;
      tests++;
      if ({result_valid, result_idx, result_killed, result_cycle, killed_count} !==
          {1'b1, 8'd1, 1'b0, 16'd0, 9'd0}) begin
         fails++;
         $display("FAIL trap_only valid=%b idx=%0d killed=%b cycle=%0d kc=%0d expected 1 1 0 0 0",
                  result_valid, result_idx, result_killed, result_cycle, killed_count);
      end
   endtask

   // Stalled REPORT with noisy miter inputs; mismatch during RESET must be ignored too.
   task automatic test_backpressure();
      do_reset();
      result_ready = 1'b0;
      start_sweep();
      mismatch = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         tick();
         mismatch = (i == 6) ? 1'b1 : 1'b0;
      end
      tests++;
      if ({result_valid, result_killed, result_cycle} !== {1'b1, 1'b1, 16'd2}) begin
         fails++;
         $display("FAIL bp_result valid=%b killed=%b cycle=%0d expected 1 1 2",
                  result_valid, result_killed, result_cycle);
      end
      mismatch = 1'b1;
      ref_trap = 1'b1;
      for (int s = 1; s <= 7; s++) begin
         tick();
         tests++;
         if ({result_valid, result_idx, result_killed, result_cycle, core_resetn, mutsel, killed_count} !==
             {1'b1, 8'd1, 1'b1, 16'd2, 1'b0, 8'd1, 9'd1}) begin
            fails++;
            $display("FAIL bp_stall%0d valid=%b idx=%0d killed=%b cycle=%0d rn=%b mutsel=%0d kc=%0d",
                     s, result_valid, result_idx, result_killed, result_cycle, core_resetn, mutsel, killed_count);
         end
      end
      mismatch = 1'b0;
      ref_trap = 1'b0;
      result_ready = 1'b1;
      tick();
      tests++;
      if ({result_valid, busy, core_resetn, mutsel} !== {1'b0, 1'b1, 1'b0, 8'd2}) begin
         fails++;
         $display("FAIL bp_resume valid=%b busy=%b rn=%b mutsel=%0d expected 0 1 0 2",
                  result_valid, busy, core_resetn, mutsel);
      end
   endtask

   task automatic test_reset_mid_run();
      do_reset();
      result_ready = 1'b1;
      start_sweep();
      for (int i = 1; i <= 14; i++) begin
         tick();
         mismatch = (i == 6) ? 1'b1 : 1'b0;
      end
      tests++;
      if ({core_resetn, mutsel, killed_count} !== {1'b1, 8'd2, 9'd1}) begin
         fails++;
         $display("FAIL pre_abort rn=%b mutsel=%0d kc=%0d expected 1 2 1",
                  core_resetn, mutsel, killed_count);
      end
      #1 reset = 1'b1;
      #1;
      tests++;
      if ({busy, done, core_resetn, result_valid, result_killed, mutsel, result_idx,
           result_cycle, killed_count} !== 46'd0) begin
         fails++;
         $display("FAIL async_reset busy=%b rn=%b valid=%b mutsel=%0d idx=%0d kc=%0d expected all 0",
                  busy, core_resetn, result_valid, mutsel, result_idx, killed_count);
      end
      tick();
      reset = 1'b0;
      start_sweep();
      tests++;
      if ({busy, mutsel, killed_count} !== {1'b1, 8'd1, 9'd0}) begin
         fails++;
         $display("FAIL resweep busy=%b mutsel=%0d kc=%0d expected 1 1 0",
                  busy, mutsel, killed_count);
      end
      for (int i = 1; i <= 14; i++) tick();
      tests++;
      if ({result_valid, result_idx, result_killed} !== {1'b1, 8'd1, 1'b0}) begin
         fails++;
         $display("FAIL resweep_result valid=%b idx=%0d killed=%b expected 1 1 0",
                  result_valid, result_idx, result_killed);
      end
   endtask

   initial begin
      test_reset();
      test_full_sweep();
      test_kill_and_restart();
      test_trap_priority();
      test_backpressure();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
